// File: rtl/rf_pkg.sv
// Shared constants for the parametrised register file.
//   RF_DW / RF_AW / RF_NREAD : default data width, address width, read-port count
//   WP_ALU / WP_MEM          : write-port indices; a higher index wins an address collision
package rf_pkg;

   localparam int unsigned RF_DW    = 32;
   localparam int unsigned RF_AW    = 5;
   localparam int unsigned RF_NREAD = 2;

   localparam int unsigned WP_ALU = 0;
   localparam int unsigned WP_MEM = 1;
   localparam int unsigned NUM_WP = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst             : clock, synchronous active-high reset (clears all busy bits)
//   rsv, rsv_en          : reserve request, sets busy[rsv] on the next edge
//   clr_addr0, clr_en0   : committed write on port 0, clears busy[clr_addr0]
//   clr_addr1, clr_en1   : committed write on port 1, clears busy[clr_addr1]
//   busy                 : registered busy vector, one bit per register
// A reserve supersedes a clear of the same register in the same cycle.
module rf_scoreboard #(
   parameter int unsigned AW       = 5,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     rsv,
   input  logic              rsv_en,
   input  logic [AW-1:0]     clr_addr0,
   input  logic              clr_en0,
   input  logic [AW-1:0]     clr_addr1,
   input  logic              clr_en1,
   output logic [2**AW-1:0]  busy
);

   logic [2**AW-1:0] busy_q, busy_d;
   logic             rsv_ok;

   assign rsv_ok = rsv_en && !(ZERO_REG && (rsv == '0));

   always_comb begin
      busy_d = busy_q;
      if (clr_en0) busy_d[clr_addr0] = 1'b0;
      if (clr_en1) busy_d[clr_addr1] = 1'b0;
      // Applied last so a new producer overrides the retiring one.
      if (rsv_ok)  busy_d[rsv] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/register_file_param.sv
// Parametrised multi-port register file with two write ports and a busy scoreboard.
//   clk, rst          : clock, synchronous active-high reset
//   rr / cr / rbusy   : N_READ read ports (address, data, busy), port i at [i*W +: W]
//   rw0/dw0/rwe0      : write port 0 (ALU result bus)
//   rw1/dw1/rwe1      : write port 1 (memory result bus), wins address collisions
//   rsv, rsv_en       : reserve destination register of an issuing instruction
// Reads are combinational; ZERO_REG hardwires register 0; BYPASS forwards same-cycle writes.
module register_file_param
   import rf_pkg::*;
#(
   parameter int unsigned DW       = RF_DW,
   parameter int unsigned AW       = RF_AW,
   parameter int unsigned N_READ   = RF_NREAD,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_READ*AW-1:0] rr,
   output logic [N_READ*DW-1:0] cr,
   output logic [N_READ-1:0]    rbusy,
   input  logic [AW-1:0]        rw0,
   input  logic [AW-1:0]        rw1,
   input  logic [DW-1:0]        dw0,
   input  logic [DW-1:0]        dw1,
   input  logic                 rwe0,
   input  logic                 rwe1,
   input  logic [AW-1:0]        rsv,
   input  logic                 rsv_en
);

   localparam int unsigned DEPTH = 2**AW;

   logic [DW-1:0]    regs [DEPTH];
   logic [AW-1:0]    wa [NUM_WP];
   logic [DW-1:0]    wd [NUM_WP];
   logic             we [NUM_WP];
   logic [DEPTH-1:0] sb_busy;

   // Effective write enables: writes to the hardwired zero register never commit.
   always_comb begin
      wa[WP_ALU] = rw0;
      wd[WP_ALU] = dw0;
      we[WP_ALU] = rwe0 && !(ZERO_REG && (rw0 == '0));
      wa[WP_MEM] = rw1;
      wd[WP_MEM] = dw1;
      we[WP_MEM] = rwe1 && !(ZERO_REG && (rw1 == '0));
   end

   // Ascending port order makes the memory port win a same-address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         for (int unsigned p = 0; p < NUM_WP; p++) begin
            if (we[p]) regs[wa[p]] <= wd[p];
         end
      end
   end

   rf_scoreboard #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .rsv       (rsv),
      .rsv_en    (rsv_en),
      .clr_addr0 (wa[WP_ALU]),
      .clr_en0   (we[WP_ALU]),
      .clr_addr1 (wa[WP_MEM]),
      .clr_en1   (we[WP_MEM]),
      .busy      (sb_busy)
   );

   for (genvar g = 0; g < N_READ; g++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          busy;
      logic          hit;

      assign addr = rr[g*AW +: AW];

      always_comb begin
         data = regs[addr];
         busy = sb_busy[addr];
         hit  = 1'b0;
         if (BYPASS) begin
            for (int unsigned p = 0; p < NUM_WP; p++) begin
               if (we[p] && (wa[p] == addr)) begin
                  data = wd[p];
                  hit  = 1'b1;
               end
            end
            // A same-cycle reserve keeps the register pending despite the write.
            if (hit && !(rsv_en && (rsv == addr))) busy = 1'b0;
         end
         if (ZERO_REG && (addr == '0)) begin
            data = '0;
            busy = 1'b0;
         end
      end

      assign cr[g*DW +: DW] = data;
      assign rbusy[g]       = busy;
   end

endmodule

// File: tb/tb_register_file_param.sv
module tb_register_file_param;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [2*AW-1:0] rr;
   logic [AW-1:0] rw0, rw1, rsv;
   logic [DW-1:0] dw0, dw1;
   logic          rwe0, rwe1, rsv_en;

   logic [2*DW-1:0] cr_nb, cr_by;
   logic [1:0]      rbusy_nb, rbusy_by;

   typedef struct {
      string       name;
      int          dut;   // 0: no bypass, 1: bypass
      int          port;
      logic [31:0] cr;
      logic        busy;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   register_file_param #(
      .DW(DW), .AW(AW), .N_READ(2), .ZERO_REG(1'b1), .BYPASS(1'b0)
   ) u_nb (
      .clk(clk), .rst(rst), .rr(rr), .cr(cr_nb), .rbusy(rbusy_nb),
      .rw0(rw0), .rw1(rw1), .dw0(dw0), .dw1(dw1), .rwe0(rwe0), .rwe1(rwe1),
      .rsv(rsv), .rsv_en(rsv_en)
   );

   register_file_param #(
      .DW(DW), .AW(AW), .N_READ(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
   ) u_by (
      .clk(clk), .rst(rst), .rr(rr), .cr(cr_by), .rbusy(rbusy_by),
      .rw0(rw0), .rw1(rw1), .dw0(dw0), .dw1(dw1), .rwe0(rwe0), .rwe1(rwe1),
      .rsv(rsv), .rsv_en(rsv_en)
   );

   // Monitor: outputs are combinational, so every queued expectation is due at the
   // negedge following the input change that produced it.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t        e;
         logic [31:0] a_cr;
         logic        a_busy;
         e = q.pop_front();
         if (e.dut == 0) begin
            a_cr   = cr_nb[e.port*32 +: 32];
            a_busy = rbusy_nb[e.port];
         end else begin
            a_cr   = cr_by[e.port*32 +: 32];
            a_busy = rbusy_by[e.port];
         end
         n_checks++;
         if (a_cr !== e.cr || a_busy !== e.busy) begin
            n_fail++;
            $display("FAIL %s dut=%0d port=%0d: cr=%h rbusy=%b, required cr=%h rbusy=%b",
                     e.name, e.dut, e.port, a_cr, a_busy, e.cr, e.busy);
         end
      end
   end

   task automatic push(input string name, input int dut, input int port,
                       input logic [31:0] d, input logic b);
      exp_t e;
      e.name = name; e.dut = dut; e.port = port; e.cr = d; e.busy = b;
      q.push_back(e);
   endtask

   // Expectation for both DUTs (no-bypass value, bypass value).
   task automatic exp2(input string name, input int port,
                       input logic [31:0] d_nb, input logic b_nb,
                       input logic [31:0] d_by, input logic b_by);
      push(name, 0, port, d_nb, b_nb);
      push(name, 1, port, d_by, b_by);
   endtask

   task automatic idle();
      rst = 1'b0; rwe0 = 1'b0; rwe1 = 1'b0; rsv_en = 1'b0;
      rw0 = '0; rw1 = '0; dw0 = '0; dw1 = '0; rsv = '0;
   endtask

   task automatic set_rr(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
      rr = {p1, p0};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      set_rr(5'd0, 5'd0);
      rst = 1'b1;
      step();
      step();

      // Reset then read.
      idle();
      set_rr(5'd4, 5'd31);
      exp2("reset_p0", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp2("reset_p1", 1, 32'h0, 1'b0, 32'h0, 1'b0);
      step();

      // Basic write; both read ports on the same register.
      rwe0 = 1'b1; rw0 = 5'd10; dw0 = 32'h0000_00AA;
      set_rr(5'd10, 5'd10);
      exp2("wr_same_cycle_p0", 0, 32'h0, 1'b0, 32'hAA, 1'b0);
      exp2("wr_same_cycle_p1", 1, 32'h0, 1'b0, 32'hAA, 1'b0);
      step();
      idle();
      exp2("wr_next_p0", 0, 32'hAA, 1'b0, 32'hAA, 1'b0);
      exp2("wr_next_p1", 1, 32'hAA, 1'b0, 32'hAA, 1'b0);
      step();

      // Dual write collision: port 1 wins.
      rwe0 = 1'b1; rw0 = 5'd7; dw0 = 32'h1111_1111;
      rwe1 = 1'b1; rw1 = 5'd7; dw1 = 32'h2222_2222;
      set_rr(5'd7, 5'd10);
      exp2("collide_same", 0, 32'h0, 1'b0, 32'h2222_2222, 1'b0);
      exp2("collide_other", 1, 32'hAA, 1'b0, 32'hAA, 1'b0);
      step();
      idle();
      exp2("collide_next", 0, 32'h2222_2222, 1'b0, 32'h2222_2222, 1'b0);
      step();

      // Writes to different addresses both commit.
      rwe0 = 1'b1; rw0 = 5'd8; dw0 = 32'h0000_0088;
      rwe1 = 1'b1; rw1 = 5'd9; dw1 = 32'h0000_0099;
      set_rr(5'd8, 5'd9);
      exp2("dual_same_p0", 0, 32'h0, 1'b0, 32'h88, 1'b0);
      exp2("dual_same_p1", 1, 32'h0, 1'b0, 32'h99, 1'b0);
      step();
      idle();
      exp2("dual_next_p0", 0, 32'h88, 1'b0, 32'h88, 1'b0);
      exp2("dual_next_p1", 1, 32'h99, 1'b0, 32'h99, 1'b0);
      step();

      // Zero register: writes and reserves ignored, even with bypass.
      rwe0 = 1'b1; rw0 = 5'd0; dw0 = 32'hFFFF_FFFF;
      set_rr(5'd0, 5'd8);
      exp2("zero_wr_same", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      idle();
      rsv_en = 1'b1; rsv = 5'd0;
      exp2("zero_after_wr", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      idle();
      exp2("zero_after_rsv", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();

      // Scoreboard.
      rsv_en = 1'b1; rsv = 5'd5;
      set_rr(5'd5, 5'd8);
      exp2("rsv_same_cycle", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      idle();
      exp2("rsv_busy", 0, 32'h0, 1'b1, 32'h0, 1'b1);
      exp2("rsv_other_idle", 1, 32'h88, 1'b0, 32'h88, 1'b0);
      step();
      rwe1 = 1'b1; rw1 = 5'd5; dw1 = 32'h0000_005A;
      rsv_en = 1'b1; rsv = 5'd5;
      exp2("wr_rsv_same", 0, 32'h0, 1'b1, 32'h5A, 1'b1);
      step();
      idle();
      exp2("wr_rsv_next", 0, 32'h5A, 1'b1, 32'h5A, 1'b1);
      step();
      rwe0 = 1'b1; rw0 = 5'd5; dw0 = 32'h0000_005B;
      exp2("clr_same", 0, 32'h5A, 1'b1, 32'h5B, 1'b0);
      step();
      idle();
      exp2("clr_next", 0, 32'h5B, 1'b0, 32'h5B, 1'b0);
      step();

      // Reset mid-operation: pending reservation and write both discarded.
      rsv_en = 1'b1; rsv = 5'd3;
      set_rr(5'd3, 5'd10);
      step();
      idle();
      exp2("pre_rst_busy", 0, 32'h0, 1'b1, 32'h0, 1'b1);
      step();
      rst = 1'b1;
      rsv_en = 1'b1; rsv = 5'd3;
      rwe0 = 1'b1; rw0 = 5'd3; dw0 = 32'h0000_0055;
      step();
      idle();
      exp2("post_rst_r3", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp2("post_rst_r10", 1, 32'h0, 1'b0, 32'h0, 1'b0);
      step();

      // Drain with a bounded wait.
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
